// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit field layout, port ids, tracker state.
// Pure declarations, no logic of its own.
// Imported by the receiver, its FIFO user and the interface.
package noc_pkg;

  localparam int FLIT_W    = 16;
  localparam int SEQ_MSB   = 15;
  localparam int SEQ_LSB   = 5;
  localparam int SRC_MSB   = 4;
  localparam int SRC_LSB   = 3;
  localparam int DEST_MSB  = 2;
  localparam int DEST_LSB  = 1;
  localparam int VALID_BIT = 0;
  localparam int SEQ_W     = SEQ_MSB - SEQ_LSB + 1;

  localparam logic [1:0] EAST  = 2'd0;
  localparam logic [1:0] WEST  = 2'd1;
  localparam logic [1:0] LOCAL = 2'd2;
  localparam logic [1:0] PORT3 = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } trk_state_t;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [1:0]       src;
    logic [1:0]       dest;
    logic             valid;
  } flit_t;

  // Split a raw flit into its named fields.
  function automatic flit_t decode_flit(input logic [FLIT_W-1:0] raw);
    flit_t f;
    f.seq   = raw[SEQ_MSB:SEQ_LSB];
    f.src   = raw[SRC_MSB:SRC_LSB];
    f.dest  = raw[DEST_MSB:DEST_LSB];
    f.valid = raw[VALID_BIT];
    return f;
  endfunction

endpackage

// File: rtl/flit_receiver_if.sv
// Router-port bundle: write/data and stall in, fill status, delivery and stats out.
// No logic; carries signals between router, consumer and receiver.
// master = router/consumer side, slave = receiver side.
interface flit_receiver_if #(parameter int WIDTH = 16);
  import noc_pkg::*;

  logic             write;
  logic [WIDTH-1:0] dataIn;
  logic             stall;
  logic             full;
  logic             almost_full;
  logic             rx_valid;
  logic [SEQ_W-1:0] rx_seq;
  logic [1:0]       rx_src;
  logic [15:0]      flit_count;
  logic [7:0]       err_count;
  logic             err_dest;
  logic             err_seq;
  logic             err_invalid;
  logic             overflow;

  modport master (
    output write, dataIn, stall,
    input  full, almost_full, rx_valid, rx_seq, rx_src, flit_count, err_count,
           err_dest, err_seq, err_invalid, overflow
  );

  modport slave (
    input  write, dataIn, stall,
    output full, almost_full, rx_valid, rx_seq, rx_src, flit_count, err_count,
           err_dest, err_seq, err_invalid, overflow
  );

endinterface

// File: rtl/noc_fifo.sv
// Input flit FIFO, DEPTH entries, head visible combinationally on dout.
// Latency: pushed entry poppable the following cycle.
// Push ignored while full; full/almost_full registered from next occupancy.
module noc_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         almost_full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Occupancy after this cycle's accepted push/pop.
  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and registered fill status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count       <= count_nxt;
      full        <= (count_nxt == CW'(DEPTH));
      almost_full <= (count_nxt >= CW'(DEPTH-1));
    end
  end

endmodule

// File: rtl/flit_receiver.sv
// NoC sink: buffers router flits, checks dest/valid/per-source sequence, keeps stats.
// Latency: write in cycle N into empty FIFO -> rx_valid in cycle N+2.
// Backpressure: stall holds the FIFO head; full/almost_full go back to the router.
module flit_receiver
  import noc_pkg::*;
#(
  parameter int         WIDTH = 16,
  parameter int         DEPTH = 8,
  parameter logic [1:0] MY_ID = 2'b00
) (
  input  logic          clk,
  input  logic          reset_n,
  flit_receiver_if.slave rx
);

  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_full;
  logic             fifo_af;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic             pop;
  logic             drop;

  trk_state_t       trk_state [4];
  logic [SEQ_W-1:0] trk_exp   [4];

  flit_t            head;
  logic             deliver;
  logic             e_dest;
  logic             e_seq;
  logic             e_inv;
  logic [1:0]       err_inc;
  logic [8:0]       err_sum;

  assign pop  = ~fifo_empty & ~rx.stall;
  // full is the registered flag, so a same-cycle pop cannot make room.
  assign drop = rx.write & fifo_full;

  assign rx.full        = fifo_full;
  assign rx.almost_full = fifo_af;

  noc_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push        (rx.write),
    .pop         (pop),
    .din         (rx.dataIn),
    .dout        (fifo_dout),
    .full        (fifo_full),
    .almost_full (fifo_af),
    .empty       (fifo_empty),
    .count       (fifo_count)
  );

  // Classify the flit being popped this cycle; results are registered together.
  always_comb begin
    head    = decode_flit(fifo_dout);
    deliver = 1'b0;
    e_dest  = 1'b0;
    e_seq   = 1'b0;
    e_inv   = 1'b0;
    if (pop) begin
      if (!head.valid) begin
        e_inv = 1'b1;
      end else begin
        deliver = 1'b1;
        e_dest  = (head.dest != MY_ID);
        e_seq   = (trk_state[head.src] == TRACK) && (head.seq != trk_exp[head.src]);
      end
    end
    err_inc = 2'(e_inv) + 2'(e_dest) + 2'(e_seq) + 2'(drop);
    err_sum = {1'b0, rx.err_count} + 9'(err_inc);
  end

  // Delivery outputs, trackers, sticky flags and counters share one update edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx.rx_valid    <= 1'b0;
      rx.rx_seq      <= '0;
      rx.rx_src      <= '0;
      rx.flit_count  <= '0;
      rx.err_count   <= '0;
      rx.err_dest    <= 1'b0;
      rx.err_seq     <= 1'b0;
      rx.err_invalid <= 1'b0;
      rx.overflow    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        trk_state[i] <= IDLE;
        trk_exp[i]   <= '0;
      end
    end else begin
      rx.rx_valid <= deliver;
      if (deliver) begin
        rx.rx_seq              <= head.seq;
        rx.rx_src              <= head.src;
        rx.flit_count          <= rx.flit_count + 16'd1;
        // Mismatch resyncs to the received seq; wraps mod 2^11.
        trk_state[head.src]    <= TRACK;
        trk_exp[head.src]      <= head.seq + SEQ_W'(1);
      end
      if (e_dest) rx.err_dest    <= 1'b1;
      if (e_seq)  rx.err_seq     <= 1'b1;
      if (e_inv)  rx.err_invalid <= 1'b1;
      if (drop)   rx.overflow    <= 1'b1;
      rx.err_count <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end
  end

  // Registered full flag must always agree with the occupancy counter.
  assert property (@(posedge clk) disable iff (!reset_n)
                   fifo_full == (fifo_count == CW'(DEPTH)));

endmodule

// File: tb/tb_flit_receiver.sv
// Self-checking bench for flit_receiver: scoreboard of delivered {seq,src}
// plus per-scenario checks of flags, counters and fill status.
module tb_flit_receiver;
  import noc_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  flit_receiver_if #(.WIDTH(16)) bus();

  flit_receiver #(.WIDTH(16), .DEPTH(8), .MY_ID(2'b00)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rx      (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [12:0] sb_q [$];
  logic [12:0] mon_exp;

  // Every delivery must match the oldest expected {seq,src}.
  always @(negedge clk) begin
    if (reset_n && bus.rx_valid === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rx: got seq=%0d src=%0d, required no delivery",
                 bus.rx_seq, bus.rx_src);
      end else begin
        mon_exp = sb_q.pop_front();
        if ({bus.rx_seq, bus.rx_src} !== mon_exp) begin
          errors++;
          $display("FAIL rx_fields: got seq=%0d src=%0d, required seq=%0d src=%0d",
                   bus.rx_seq, bus.rx_src, mon_exp[12:2], mon_exp[1:0]);
        end
      end
    end
  end

  function automatic logic [15:0] mk(input int seq, input int src, input int dest, input int v);
    logic [15:0] f;
    f = {seq[10:0], src[1:0], dest[1:0], v[0]};
    return f;
  endfunction

  task automatic send(input int seq, input int src, input int dest, input int v, input bit exp_rx);
    @(posedge clk); #1;
    bus.write  = 1'b1;
    bus.dataIn = mk(seq, src, dest, v);
    if (exp_rx) sb_q.push_back({seq[10:0], src[1:0]});
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.write = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0; bus.write = 1'b0; bus.stall = 1'b0; bus.dataIn = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    sb_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b, required 0", bus.full); end
    checks++; if (bus.almost_full !== 1'b0) begin errors++; $display("FAIL rst_af: got %b, required 0", bus.almost_full); end
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid: got %b, required 0", bus.rx_valid); end
    checks++; if ({bus.rx_seq, bus.rx_src} !== 13'd0) begin errors++; $display("FAIL rst_rx_fields: got %h, required 0", {bus.rx_seq, bus.rx_src}); end
    checks++; if (bus.flit_count !== 16'd0) begin errors++; $display("FAIL rst_flit_count: got %0d, required 0", bus.flit_count); end
    checks++; if (bus.err_count !== 8'd0) begin errors++; $display("FAIL rst_err_count: got %0d, required 0", bus.err_count); end
    checks++; if ({bus.err_dest, bus.err_seq, bus.err_invalid, bus.overflow} !== 4'b0000) begin
      errors++; $display("FAIL rst_flags: got %b, required 0000", {bus.err_dest, bus.err_seq, bus.err_invalid, bus.overflow});
    end
    @(posedge clk); #1 reset_n = 1'b1;
  endtask

  task automatic test_stream();
    do_reset();
    send(0, 1, 0, 1, 1);
    @(negedge clk);
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL lat_cycle_n: got %b, required 0", bus.rx_valid); end
    @(posedge clk); #1 bus.write = 1'b0;
    @(negedge clk);
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL lat_cycle_n1: got %b, required 0", bus.rx_valid); end
    @(negedge clk);
    checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL lat_cycle_n2: got %b, required 1", bus.rx_valid); end
    for (int s = 1; s < 20; s++) send(s, 1, 0, 1, 1);
    idle();
    drain(40);
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL stream_pending: got %0d, required 0", sb_q.size()); end
    checks++; if (bus.flit_count !== 16'd20) begin errors++; $display("FAIL stream_flit_count: got %0d, required 20", bus.flit_count); end
    checks++; if (bus.err_count !== 8'd0) begin errors++; $display("FAIL stream_err_count: got %0d, required 0", bus.err_count); end
  endtask

  task automatic test_backpressure();
    logic af_d;
    logic w;
    int   sent;
    do_reset();
    bus.stall = 1'b1;
    af_d = 1'b0;
    sent = 0;
    // Writer reacts to almost_full one cycle late, like a registered router.
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      w    = ~af_d;
      af_d = bus.almost_full;
      if (w) begin
        bus.write  = 1'b1;
        bus.dataIn = mk(sent, 3, 0, 1);
        sb_q.push_back({sent[10:0], 2'd3});
        sent++;
      end else begin
        bus.write = 1'b0;
      end
    end
    @(negedge clk);
    checks++; if (sent != 8) begin errors++; $display("FAIL bp_sent: got %0d, required 8", sent); end
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL bp_full: got %b, required 1", bus.full); end
    checks++; if (bus.almost_full !== 1'b1) begin errors++; $display("FAIL bp_af: got %b, required 1", bus.almost_full); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL bp_overflow: got %b, required 0", bus.overflow); end
    checks++; if (bus.flit_count !== 16'd0) begin errors++; $display("FAIL bp_stalled_count: got %0d, required 0", bus.flit_count); end
    @(posedge clk); #1 bus.stall = 1'b0;
    drain(30);
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL bp_pending: got %0d, required 0", sb_q.size()); end
    checks++; if (bus.flit_count !== 16'd8) begin errors++; $display("FAIL bp_flit_count: got %0d, required 8", bus.flit_count); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL bp_full_after: got %b, required 0", bus.full); end
  endtask

  task automatic test_overflow();
    do_reset();
    bus.stall = 1'b1;
    for (int s = 0; s < 8; s++) send(s, 1, 0, 1, 1);
    idle();
    // Write into a full FIFO while popping in the same cycle: still dropped.
    @(posedge clk); #1;
    bus.write = 1'b1; bus.dataIn = mk(8, 1, 0, 1); bus.stall = 1'b0;
    @(posedge clk); #1 bus.write = 1'b0;
    @(negedge clk);
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b, required 1", bus.overflow); end
    checks++; if (bus.err_count !== 8'd1) begin errors++; $display("FAIL ovf_err_count: got %0d, required 1", bus.err_count); end
    drain(30);
    checks++; if (bus.flit_count !== 16'd8) begin errors++; $display("FAIL ovf_flit_count: got %0d, required 8", bus.flit_count); end
    send(8, 1, 0, 1, 1);
    idle();
    drain(20);
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL ovf_pending: got %0d, required 0", sb_q.size()); end
    checks++; if (bus.err_count !== 8'd1) begin errors++; $display("FAIL ovf_err_after: got %0d, required 1", bus.err_count); end
    checks++; if (bus.err_seq !== 1'b0) begin errors++; $display("FAIL ovf_err_seq: got %b, required 0", bus.err_seq); end
    checks++; if (bus.flit_count !== 16'd9) begin errors++; $display("FAIL ovf_flit_after: got %0d, required 9", bus.flit_count); end
  endtask

  task automatic test_seq_wrap();
    do_reset();
    send(2046, 2, 0, 1, 1);
    send(2047, 2, 0, 1, 1);
    send(0, 2, 0, 1, 1);
    send(1, 2, 0, 1, 1);
    idle();
    drain(20);
    checks++; if (bus.err_seq !== 1'b0) begin errors++; $display("FAIL wrap_err_seq: got %b, required 0", bus.err_seq); end
    checks++; if (bus.err_count !== 8'd0) begin errors++; $display("FAIL wrap_err_count: got %0d, required 0", bus.err_count); end
    send(5, 2, 0, 1, 1);
    idle();
    drain(20);
    checks++; if (bus.err_seq !== 1'b1) begin errors++; $display("FAIL gap_err_seq: got %b, required 1", bus.err_seq); end
    checks++; if (bus.err_count !== 8'd1) begin errors++; $display("FAIL gap_err_count: got %0d, required 1", bus.err_count); end
    send(6, 2, 0, 1, 1);
    idle();
    drain(20);
    checks++; if (bus.err_count !== 8'd1) begin errors++; $display("FAIL resync_err_count: got %0d, required 1", bus.err_count); end
    checks++; if (bus.flit_count !== 16'd6) begin errors++; $display("FAIL resync_flit_count: got %0d, required 6", bus.flit_count); end
  endtask

  task automatic test_dest_invalid();
    do_reset();
    send(10, 0, 3, 1, 1);
    idle();
    drain(20);
    checks++; if (bus.err_dest !== 1'b1) begin errors++; $display("FAIL dest_flag: got %b, required 1", bus.err_dest); end
    checks++; if (bus.err_count !== 8'd1) begin errors++; $display("FAIL dest_err_count: got %0d, required 1", bus.err_count); end
    checks++; if (bus.flit_count !== 16'd1) begin errors++; $display("FAIL dest_flit_count: got %0d, required 1", bus.flit_count); end
    send(11, 0, 0, 0, 0);
    idle();
    drain(20);
    checks++; if (bus.err_invalid !== 1'b1) begin errors++; $display("FAIL inv_flag: got %b, required 1", bus.err_invalid); end
    checks++; if (bus.err_count !== 8'd2) begin errors++; $display("FAIL inv_err_count: got %0d, required 2", bus.err_count); end
    checks++; if (bus.flit_count !== 16'd1) begin errors++; $display("FAIL inv_flit_count: got %0d, required 1", bus.flit_count); end
    checks++; if (bus.err_seq !== 1'b0) begin errors++; $display("FAIL inv_err_seq: got %b, required 0", bus.err_seq); end
    // Invalid flit left tracker at 11: seq 20 with bad dest is two errors.
    send(20, 0, 3, 1, 1);
    idle();
    drain(20);
    checks++; if (bus.err_count !== 8'd4) begin errors++; $display("FAIL multi_err_count: got %0d, required 4", bus.err_count); end
    checks++; if (bus.err_seq !== 1'b1) begin errors++; $display("FAIL multi_err_seq: got %b, required 1", bus.err_seq); end
    checks++; if (bus.flit_count !== 16'd2) begin errors++; $display("FAIL multi_flit_count: got %0d, required 2", bus.flit_count); end
  endtask

  task automatic test_reset_midburst();
    do_reset();
    send(50, 1, 3, 1, 1);
    idle();
    drain(20);
    bus.stall = 1'b1;
    for (int s = 100; s < 104; s++) send(s, 1, 0, 1, 1);
    idle();
    @(posedge clk); #1;
    reset_n = 1'b0;
    sb_q.delete();
    #1;
    checks++; if (bus.flit_count !== 16'd0) begin errors++; $display("FAIL mid_flit_count: got %0d, required 0", bus.flit_count); end
    checks++; if (bus.err_count !== 8'd0) begin errors++; $display("FAIL mid_err_count: got %0d, required 0", bus.err_count); end
    checks++; if (bus.err_dest !== 1'b0) begin errors++; $display("FAIL mid_err_dest: got %b, required 0", bus.err_dest); end
    checks++; if ({bus.rx_seq, bus.rx_src} !== 13'd0) begin errors++; $display("FAIL mid_rx_fields: got %h, required 0", {bus.rx_seq, bus.rx_src}); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus.stall = 1'b0;
    send(7, 1, 0, 1, 1);
    idle();
    drain(20);
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL mid_pending: got %0d, required 0", sb_q.size()); end
    checks++; if (bus.err_seq !== 1'b0) begin errors++; $display("FAIL mid_err_seq: got %b, required 0", bus.err_seq); end
    checks++; if (bus.err_count !== 8'd0) begin errors++; $display("FAIL mid_err_after: got %0d, required 0", bus.err_count); end
    checks++; if (bus.flit_count !== 16'd1) begin errors++; $display("FAIL mid_flit_after: got %0d, required 1", bus.flit_count); end
  endtask

  initial begin
    bus.write  = 1'b0;
    bus.dataIn = '0;
    bus.stall  = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_overflow();
    test_seq_wrap();
    test_dest_invalid();
    test_reset_midburst();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
